functional_unit_pipe: RTL and testbench

FUNCTIONAL_UNIT_PIPE -- requirements
Module: functional_unit_pipe

---
 rtl/functional_unit_pipe.sv | 146 ++++++++++++++
 tb/tb_functional_unit_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/functional_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : functional_unit_pipe                                   |
// | Description : Two-stage valid/ready ALU pipeline. The opcode is the  |
// |               index of the highest set instruction bit. The select   |
// |               field picks an operand pair, and eight ops are         |
// |               available. Optional macro FU_SATURATE_EN makes op 0    |
// |               saturate to all-ones on carry-out.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module functional_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       instruction,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             err
);

  // Stage 1 holding registers
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;
  logic             r_s1_err;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  logic             r_err;

  // Decode and execute wires
  logic [2:0]       w_opcode;
  logic             w_zero;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_rotr;
  logic [WIDTH-1:0] w_rotl;
  logic [WIDTH-1:0] w_result;
  logic             w_s1_load;
  logic             w_s2_load;
`ifdef FU_SATURATE_EN
  logic             w_carry;
`endif

  // Handshake: S2 takes a new value when empty or draining; S1 when empty or
  // emptying into S2. in_ready depends on out_ready only, never on in_valid.
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign err       = r_err;

  // Priority encode: the highest set instruction bit wins; all-zero flags err
  always_comb begin
    w_opcode = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (instruction[i]) w_opcode = 3'(i);
    end
    w_zero = (instruction == 8'h00);
  end

  // Operand pair selection
  always_comb begin
    case (select)
      3'b011:  begin w_x = b; w_y = c; end
      3'b101:  begin w_x = a; w_y = c; end
      3'b110:  begin w_x = a; w_y = b; end
      default: begin w_x = c; w_y = a; end
    endcase
  end

  // Stage 1: capture decoded opcode and operands on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 3'd0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_valid <= in_valid;
      if (in_valid && w_s1_load) begin
        r_s1_op  <= w_opcode;
        r_s1_x   <= w_x;
        r_s1_y   <= w_y;
        r_s1_err <= w_zero;
      end
    end
  end

  // Shared adder for op 0 plus the single-bit rotates used by ops 6 and 7
`ifdef FU_SATURATE_EN
  assign {w_carry, w_add} = {1'b0, r_s1_x} + {1'b0, r_s1_y};
`else
  assign w_add = r_s1_x + r_s1_y;
`endif
  assign w_rotr = {r_s1_x[0], r_s1_x[WIDTH-1:1]};
  assign w_rotl = {r_s1_x[WIDTH-2:0], r_s1_x[WIDTH-1]};

  // Execute the stage-1 operation
  always_comb begin
    case (r_s1_op)
`ifdef FU_SATURATE_EN
      3'd0:    w_result = w_carry ? {WIDTH{1'b1}} : w_add;
`else
      3'd0:    w_result = w_add;
`endif
      3'd1:    w_result = r_s1_x + ~r_s1_y;
      3'd2:    w_result = r_s1_x & r_s1_y;
      3'd3:    w_result = r_s1_x | r_s1_y;
      3'd4:    w_result = (r_s1_x > r_s1_y) ? r_s1_x : r_s1_y;
      3'd5:    w_result = (r_s1_x < r_s1_y) ? r_s1_x : r_s1_y;
      3'd6:    w_result = w_rotr + r_s1_y;
      default: w_result = w_rotl + r_s1_y;
    endcase
  end

  // Stage 2: register the result; hold f/err steady while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_err       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_f   <= w_result;
        r_err <= r_s1_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_functional_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_functional_unit_pipe                                |
// | Description : Self-checking bench for functional_unit_pipe. It uses  |
// |               a queue-based reference model with literal pins, and   |
// |               follows FU_SATURATE_EN when that macro is defined.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_functional_unit_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   instruction = 8'h00;
  logic [2:0]   select = 3'b000;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         in_ready, out_valid, err;
  logic [W-1:0] f;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] f;
    logic         err;
    int           t;
  } exp_t;
  exp_t q[$];

  functional_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .select(select), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {err, f} from the instruction rules with plain arithmetic
  function automatic logic [W:0] model(input logic [7:0] ins, input logic [2:0] sel,
                                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                                       input logic [W-1:0] cc);
    int           op;
    logic [W-1:0] x, y, r;
    logic [W:0]   s;
    op = 0;
    for (int i = 0; i < 8; i++) if (ins[i]) op = i;
    case (sel)
      3'b011:  begin x = bb; y = cc; end
      3'b101:  begin x = aa; y = cc; end
      3'b110:  begin x = aa; y = bb; end
      default: begin x = cc; y = aa; end
    endcase
    s = {1'b0, x} + {1'b0, y};
    case (op)
      0: begin
        r = s[W-1:0];
`ifdef FU_SATURATE_EN
        if (s[W]) r = '1;
`endif
      end
      1:       r = x + ~y;
      2:       r = x & y;
      3:       r = x | y;
      4:       r = (x >= y) ? x : y;
      5:       r = (x <= y) ? x : y;
      6:       r = ((x >> 1) | (x << (W - 1))) + y;
      default: r = ((x << 1) | (x >> (W - 1))) + y;
    endcase
    return {(ins == 8'h00), r};
  endfunction

  // Per-cycle compare against the model: beats are timestamped at accept and
  // the oldest one must be visible two cycles later and stay until taken.
  initial begin
    int           cyc;
    logic         pstall;
    logic [W-1:0] pf;
    logic         perr;
    logic [W:0]   e;
    exp_t         ent;
    cyc = 0;
    pstall = 1'b0;
    pf = '0;
    perr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_f", 64'(f), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        pstall = 1'b0;
      end else begin
        check("out_valid", 64'(out_valid), 64'(q.size() > 0 && (cyc - q[0].t) >= 2));
        check("in_ready", 64'(in_ready), 64'(!(q.size() >= 2 && !out_ready)));
        if (pstall) check("stall_hold", 64'({out_valid, err, f}), 64'({1'b1, perr, pf}));
        if (out_valid && q.size() > 0) begin
          check("f", 64'(f), 64'(q[0].f));
          check("err", 64'(err), 64'(q[0].err));
        end
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          e = model(instruction, select, a, b, c);
          ent.f = e[W-1:0];
          ent.err = e[W];
          ent.t = cyc;
          q.push_back(ent);
        end
        pstall = out_valid && !out_ready;
        pf = f;
        perr = err;
      end
      cyc++;
    end
  end

  // One isolated beat with out_ready high, checked against literal values
  task automatic directed(input logic [7:0] ins, input logic [2:0] sel,
                          input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [W-1:0] cc,
                          input logic [W-1:0] ef, input logic ee, input string nm);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    instruction = ins; select = sel; a = aa; b = bb; c = cc;
    in_valid = 1'b1;
    for (lat = 0; lat < 8; lat++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    check({nm, "_latency"}, 64'(lat), 64'(2));
    check({nm, "_f"}, 64'(f), 64'(ef));
    check({nm, "_err"}, 64'(err), 64'(ee));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic rand_beat();
    case ($urandom_range(0, 3))
      0:       instruction = 8'h00;
      1:       instruction = 8'h01 << $urandom_range(0, 7);
      default: instruction = 8'($urandom);
    endcase
    select = 3'($urandom);
    a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    c = 8'($urandom);
  endtask

  // Stream n beats; fixed mode stalls out_ready for cycles 3..5, random mode
  // randomizes both in_valid and out_ready. A held beat is never changed.
  task automatic run_stream(input int n, input bit rnd, output bit saw_full, output int cyc);
    int sent;
    bit acc;
    sent = 0;
    acc = 1'b0;
    cyc = 0;
    saw_full = 1'b0;
    while (sent < n && cyc < 5000) begin
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (sent < n) begin
        if (!in_valid || acc) begin
          rand_beat();
          in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!in_ready) saw_full = 1'b1;
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'(n));
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    bit full_seen;
    int ncyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_reset", 64'(in_ready), 64'(1));

    directed(8'h01, 3'b000, 8'd3, 8'd0, 8'd5, 8'd8, 1'b0, "add_basic");
    directed(8'h00, 3'b110, 8'd7, 8'd9, 8'd0, 8'd16, 1'b1, "zero_instr");
    directed(8'h03, 3'b110, 8'd10, 8'd3, 8'd0, 8'd6, 1'b0, "op1_notadd");
`ifdef FU_SATURATE_EN
    directed(8'h01, 3'b110, 8'd200, 8'd100, 8'd0, 8'd255, 1'b0, "add_carry");
`else
    directed(8'h01, 3'b110, 8'd200, 8'd100, 8'd0, 8'd44, 1'b0, "add_carry");
`endif
    directed(8'h40, 3'b110, 8'h81, 8'h01, 8'h00, 8'hC1, 1'b0, "op6_rotr");
    directed(8'h80, 3'b110, 8'h81, 8'h01, 8'h00, 8'h04, 1'b0, "op7_rotl");
    directed(8'h10, 3'b110, 8'hF0, 8'h0F, 8'h00, 8'hF0, 1'b0, "op4_max");
    directed(8'h20, 3'b110, 8'hF0, 8'h0F, 8'h00, 8'h0F, 1'b0, "op5_min");
    directed(8'h04, 3'b011, 8'h00, 8'hF0, 8'h3C, 8'h30, 1'b0, "op2_and");
    directed(8'h08, 3'b101, 8'h0F, 8'h00, 8'h30, 8'h3F, 1'b0, "op3_or");

    // Six back-to-back beats with a three-cycle downstream stall
    run_stream(6, 1'b0, full_seen, ncyc);
    check("stream_in_ready_dropped", 64'(full_seen), 64'(1));
    check("stream_cycles", 64'(ncyc), 64'(10));

    // Randomized traffic on both handshakes
    run_stream(300, 1'b1, full_seen, ncyc);

    // Reset with two beats in flight
    @(posedge clk);
    #1 out_ready = 1'b0;
    rand_beat();
    in_valid = 1'b1;
    @(posedge clk);
    #1 rand_beat();
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre_reset_out_valid", 64'(out_valid), 64'(1));
    check("pre_reset_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'(0));
    check("async_reset_f", 64'(f), 64'(0));
    check("async_reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    directed(8'h01, 3'b110, 8'd20, 8'd22, 8'd0, 8'd42, 1'b0, "post_reset");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
